// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: LEGv8 fetch sequencer (fetch PC, imem addressing, 2-entry prefetch FIFO to decode, redirect, halt on zero word)
module imem_fetch_ctrl #(
  parameter int PC_W = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter bit HALT_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_q,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [PC_W-1:0]   instr_pc,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              halted,
  output logic [1:0]        fifo_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nx;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] pc_q [2];
  logic [DATA_W-1:0] word_q [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] count;
  logic pop, can_enq, zero_hit, push;
  assign pop = instr_valid && instr_ready;
  assign can_enq = state == RUN && !redirect && (count != 2'd2 || pop);
  assign zero_hit = HALT_ON_ZERO && imem_q == '0;
  assign push = can_enq && !zero_hit;
  assign imem_addr = fetch_pc[ADDR_W+1:2];
  assign instr_valid = count != 2'd0;
  assign instr = word_q[rd_ptr];
  assign instr_pc = pc_q[rd_ptr];
  assign halted = state == HALT;
  assign fifo_count = count;
  always_comb begin
    state_nx = state;
    state_nx = redirect ? RUN : (can_enq && zero_hit) ? HALT : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i] <= '0;
        word_q[i] <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~{{(PC_W-2){1'b0}}, 2'b11};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wr_ptr] <= fetch_pc;
        word_q[wr_ptr] <= imem_q;
        wr_ptr <= ~wr_ptr;
        fetch_pc <= fetch_pc + PC_W'(4);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: scoreboard bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] imem_addr;
  logic [31:0] imem_q;
  logic instr_valid;
  logic instr_ready = 1'b1;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic halted;
  logic [1:0] fifo_count;
  logic [31:0] mem [64];
  typedef struct packed {logic [63:0] pc; logic [31:0] w;} exp_t;
  exp_t q [$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign imem_q = mem[imem_addr];
  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .fifo_count(fifo_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_prog();
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h8b1f03e0; mem[1] = 32'h8b1f0001; mem[2] = 32'h8b1f0022; mem[3] = 32'h8b1f0043;
    mem[4] = 32'h91000421; mem[5] = 32'hf8008001; mem[6] = 32'h91000842; mem[7] = 32'hf8018003;
  endtask
  task automatic push_exp(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] p;
      p = start + 64'(4 * i);
      q.push_back('{pc: p, w: mem[p[7:2]]});
    end
  endtask
  task automatic wait_halt(input string tag);
    int n = 0;
    while (!(halted && fifo_count == 2'd0) && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_halted"}, 64'(halted), 64'd1);
    chk({tag, "_drained"}, 64'(q.size()), 64'd0);
    tick();
    chk({tag, "_valid_low"}, 64'(instr_valid), 64'd0);
  endtask
  always @(negedge clk) begin
    if (!reset && !redirect && instr_valid && instr_ready) begin
      if (q.size() == 0) chk("extra_pop", instr_pc, 64'hffff_ffff_ffff_ffff);
      else begin
        mon_e = q.pop_front();
        chk("pop_pc", instr_pc, mon_e.pc);
        chk("pop_instr", 64'(instr), 64'(mon_e.w));
      end
    end
  end
  initial begin
    load_prog();
    tick();
    tick();
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", instr_pc, 64'd0);
    push_exp(64'h0, 8);
    reset = 1'b0;
    tick();
    chk("first_valid", 64'(instr_valid), 64'd1);
    wait_halt("run");
    chk("halt_addr", 64'(imem_addr), 64'd8);
    reset = 1'b1;
    instr_ready = 1'b0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("bp_count", 64'(fifo_count), 64'd2);
    chk("bp_addr", 64'(imem_addr), 64'd2);
    push_exp(64'h0, 8);
    instr_ready = 1'b1;
    wait_halt("bp");
    reset = 1'b1;
    instr_ready = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rd_full", 64'(fifo_count), 64'd2);
    redirect = 1'b1;
    redirect_pc = 64'h16;
    instr_ready = 1'b1;
    push_exp(64'h14, 3);
    tick();
    redirect = 1'b0;
    chk("rd_flush", 64'(fifo_count), 64'd0);
    chk("rd_gap", 64'(instr_valid), 64'd0);
    tick();
    chk("rd_valid", 64'(instr_valid), 64'd1);
    chk("rd_pc", instr_pc, 64'h14);
    chk("rd_instr", 64'(instr), 64'hf8008001);
    wait_halt("rd");
    redirect = 1'b1;
    redirect_pc = 64'h4;
    push_exp(64'h4, 7);
    tick();
    redirect = 1'b0;
    chk("resume_halted", 64'(halted), 64'd0);
    wait_halt("resume");
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    redirect = 1'b1;
    redirect_pc = 64'hf8;
    push_exp(64'hf8, 4);
    tick();
    redirect = 1'b0;
    chk("wrap_addr0", 64'(imem_addr), 64'd62);
    tick();
    chk("wrap_addr1", 64'(imem_addr), 64'd63);
    tick();
    chk("wrap_addr2", 64'(imem_addr), 64'd0);
    tick();
    chk("wrap_addr3", 64'(imem_addr), 64'd1);
    begin
      int n = 0;
      while (q.size() != 0 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      instr_ready = 1'b0;
      chk("wrap_drained", 64'(q.size()), 64'd0);
    end
    tick();
    tick();
    chk("mid_full", 64'(fifo_count), 64'd2);
    reset = 1'b1;
    tick();
    chk("mid_valid", 64'(instr_valid), 64'd0);
    chk("mid_count", 64'(fifo_count), 64'd0);
    chk("mid_halted", 64'(halted), 64'd0);
    chk("mid_addr", 64'(imem_addr), 64'd0);
    load_prog();
    push_exp(64'h0, 8);
    instr_ready = 1'b1;
    reset = 1'b0;
    wait_halt("refetch");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction fetch sequencer for the LEGv8 core's 64-word instruction memory (imem: 6-bit word address in, 32-bit word out, combinational read).
- Owns the fetch PC and drives imem addressing.
- Buffers fetched words with their PCs in a 2-entry prefetch FIFO and hands them to decode over a valid/ready handshake.
- Handles branch redirects and stops fetching at an all-zero word (program end).

Parameters:
PC_W, 64, fetch PC width (bytes)
ADDR_W, 6, imem word-address width
DATA_W, 32, instruction width
RESET_PC, 0, fetch PC after reset
HALT_ON_ZERO, 1, if 1 an all-zero fetched word halts fetch

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
imem_addr  out  ADDR_W  word address to imem, = fetch_pc[ADDR_W+1:2]
imem_q  in  DATA_W  imem read data, valid same cycle
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode accepts head
instr  out  DATA_W  head instruction
instr_pc  out  PC_W  head instruction PC
redirect  in  1  one-cycle branch/jump request
redirect_pc  in  PC_W  redirect target (bits [1:0] ignored)
halted  out  1  fetch stopped on zero word
fifo_count  out  2  FIFO occupancy 0..2

Behaviour:
- Reset (synchronous, active-high; also mid-operation): fetch_pc=RESET_PC; FIFO emptied; state RUN. Outputs: instr_valid=0, instr=0, instr_pc=0, halted=0, fifo_count=0. imem_addr=RESET_PC[ADDR_W+1:2].
- States:
  - RUN: fetching.
  - HALT: no fetch; FIFO still drains.
- Pop: instr_valid && instr_ready. instr_valid = (count>0). instr and instr_pc come from registered FIFO head storage.
- Enqueue, in RUN without redirect: when count<2, or count==2 with pop in the same cycle:
  - word=imem_q, pc=fetch_pc.
  - fetch_pc += 4 (full PC_W add).
  - Push and pop in the same cycle leave count unchanged; FIFO order is preserved.
- No enqueue when full without pop: fetch_pc holds and imem_addr is stable.
- Latency: word at fetch_pc is presented on instr/instr_valid the cycle after it is addressed, given an empty FIFO. Sustained throughput is 1 instr/cycle with instr_ready=1.
- Zero word, HALT_ON_ZERO=1: if imem_q==0 when an enqueue would occur:
  - The word is not enqueued and fetch_pc holds (points at the zero word).
  - State goes to HALT; halted=1 from the next cycle.
- Zero word, HALT_ON_ZERO=0: zero words are ordinary instructions.
- Redirect, highest priority after reset:
  - FIFO cleared; count=0 next cycle.
  - A pop in the same cycle counts as accepted; the consumer discards it.
  - No enqueue that cycle.
  - fetch_pc <= {redirect_pc[PC_W-1:2],2'b00}; state RUN; halted=0 next cycle.
  - First instruction at the target is valid 2 cycles after the redirect cycle.
- Wrap-around: imem_addr uses only fetch_pc[ADDR_W+1:2]. fetch_pc 0xFC -> 0x100 addresses word 0 while instr_pc reports 0x100.
- Redirect while HALT: resumes fetching. Redirect to a zero word: re-enters HALT one cycle later, with nothing enqueued.
- instr/instr_pc hold their last values when instr_valid=0. They are don't-care for checking.

Test Plan:
- Imem words: [0]=0x8b1f03e0, [1]=0x8b1f0001 … [7]=0xf8018003, [8]=0. Release reset, ready=1 -> instr_valid rises the cycle after reset release. Sequence is pc 0x0..0x1C with words 0x8b1f03e0..0xf8018003, one per cycle. halted=1 after pc 0x20 is fetched; fifo_count reaches 0; instr_valid=0 thereafter.
- Backpressure: ready=0 for 5 cycles after reset -> fifo_count=2, imem_addr stuck at 2. Release -> pcs 0x0, 0x4, 0x8 in order, no drop or duplication.
- Redirect to 0x14 while FIFO holds 2 entries -> fifo_count=0 next cycle. Then instr_pc=0x14, instr=0xf8008001 valid 2 cycles after the redirect. Old entries are never presented.
- Redirect to 0x4 while halted -> halted=0 next cycle; pcs 0x4..0x1C replay; halts again.
- Wrap: imem all non-zero, redirect to 0xF8 -> instr_pc 0xF8, 0xFC, 0x100, 0x104. imem_addr is 62, 63, 0, 1.
- Reset asserted mid-stream with FIFO full -> next cycle instr_valid=0, fifo_count=0, halted=0, imem_addr=0. Refetch starts from 0x0.
